// File: rtl/asi_pkg.sv
// Shared types for the SRAM write/read arbiter: FSM states and requester sides.
// Latency: n/a (types and helper only).
// Backpressure: n/a.
package asi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } arb_state_e;

  typedef enum logic {
    SIDE_W = 1'b0,
    SIDE_R = 1'b1
  } arb_side_e;

  // Width of the per-grant beat counter used by the optional beat cap.
  localparam int BEAT_CNT_W = 8;

  // The side that should be favoured after the given side finishes a grant.
  function automatic arb_side_e other_side(input arb_side_e s);
    return (s == SIDE_W) ? SIDE_R : SIDE_W;
  endfunction

endpackage

// File: rtl/asi_rd_pipe.sv
// Read-return qualifier delay: carries valid/last of each accepted read beat.
// Latency: exactly LAT cycles from in_vld_i to out_vld_o.
// Backpressure: none; the consumer always accepts, async clear drops in-flight beats.
module asi_rd_pipe #(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_vld_i,
  input  logic in_last_i,
  output logic out_vld_o,
  output logic out_last_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] last_q;

  // Shift valid/last one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= in_vld_i;
      last_q[0] <= in_vld_i & in_last_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign out_vld_o  = vld_q[LAT-1];
  assign out_last_o = last_q[LAT-1];

endmodule

// File: rtl/asi_mem_arb.sv
// Write/read burst arbiter onto one single-port SRAM, round-robin with burst lock.
// Latency: grant one cycle after request in IDLE; SRAM access same cycle as beat; read return RD_LAT.
// Backpressure: w_ready/r_ready only for the granted side; read return has none. Macro ASI_ARB_BEATCAP_EN adds a per-grant beat cap.
module asi_mem_arb
  import asi_pkg::*;
#(
  parameter int AXI_AW    = 40,
  parameter int AXI_DW    = 128,
  parameter int MEM_AW    = 10,
  parameter int RD_LAT    = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [AXI_AW-1:0]     w_addr,
  input  logic [AXI_DW-1:0]     w_data,
  input  logic [AXI_DW/8-1:0]   w_strb,
  input  logic                  w_last,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [AXI_AW-1:0]     r_addr,
  input  logic                  r_last,
  output logic [AXI_DW-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [AXI_DW-1:0]     mem_wdata,
  output logic [AXI_DW/8-1:0]   mem_be,
  input  logic [AXI_DW-1:0]     mem_rdata
);

  localparam int BW  = AXI_DW / 8;
  localparam int OFS = $clog2(BW);

  arb_state_e state_q;
  arb_side_e  ptr_q;
  logic       w_rdy_q;
  logic       r_rdy_q;

  logic w_acc, r_acc;
  logic w_rel, r_rel;
  logic w_cap, r_cap;

  // A beat is accepted only on the side whose ready is registered high.
  assign w_acc = w_rdy_q & w_valid;
  assign r_acc = r_rdy_q & r_valid;

`ifdef ASI_ARB_BEATCAP_EN
  localparam logic [BEAT_CNT_W-1:0] CAP = BEAT_CNT_W'(MAX_BEATS);

  logic [BEAT_CNT_W-1:0] cnt_q;
  logic [BEAT_CNT_W-1:0] cnt_d;

  // Count includes the beat accepted this cycle; saturate rather than wrap.
  assign cnt_d = ((w_acc | r_acc) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign w_cap = (state_q == WBURST) && (cnt_d >= CAP) && r_valid;
  assign r_cap = (state_q == RBURST) && (cnt_d >= CAP) && w_valid;
`else
  assign w_cap = 1'b0;
  assign r_cap = 1'b0;
`endif

  assign w_rel = (w_acc & w_last) | w_cap;
  assign r_rel = (r_acc & r_last) | r_cap;

  // Arbitration FSM with registered readies; pointer names the favoured side on contention.
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state_q <= IDLE;
      ptr_q   <= SIDE_W;
      w_rdy_q <= 1'b0;
      r_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_valid && (!r_valid || ptr_q == SIDE_W)) begin
            state_q <= WBURST;
            w_rdy_q <= 1'b1;
          end else if (r_valid) begin
            state_q <= RBURST;
            r_rdy_q <= 1'b1;
          end
        end
        WBURST: begin
          if (w_rel) begin
            state_q <= IDLE;
            w_rdy_q <= 1'b0;
            ptr_q   <= other_side(SIDE_W);
          end
        end
        RBURST: begin
          if (r_rel) begin
            state_q <= IDLE;
            r_rdy_q <= 1'b0;
            ptr_q   <= other_side(SIDE_R);
          end
        end
        default: begin
          state_q <= IDLE;
          w_rdy_q <= 1'b0;
          r_rdy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASI_ARB_BEATCAP_EN
  // Beats accepted in the current grant; cleared whenever the grant ends.
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || w_rel || r_rel) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign w_ready = w_rdy_q;
  assign r_ready = r_rdy_q;

  // SRAM port follows the accepted beat combinationally; idle values forced to 0.
  assign mem_en    = w_acc | r_acc;
  assign mem_we    = w_acc;
  assign mem_addr  = w_acc ? w_addr[MEM_AW+OFS-1:OFS] :
                     r_acc ? r_addr[MEM_AW+OFS-1:OFS] : '0;
  assign mem_wdata = w_acc ? w_data : '0;
  assign mem_be    = w_acc ? w_strb : '0;

  // Upper address bits wrap away; sub-word bits select nothing in a word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr[AXI_AW-1:MEM_AW+OFS], w_addr[OFS-1:0],
                              r_addr[AXI_AW-1:MEM_AW+OFS], r_addr[OFS-1:0]};

  asi_rd_pipe #(
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i      (usr_clk),
    .rst_i      (usr_reset),
    .in_vld_i   (r_acc),
    .in_last_i  (r_last),
    .out_vld_o  (rd_valid),
    .out_last_o (rd_last)
  );

  // Data is only meaningful when qualified; keep it at 0 otherwise.
  assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_asi_mem_arb.sv
// Bench for asi_mem_arb: SRAM model, stimulus-side shadow memory, read-return scoreboard.
// Latency: checks RD_LAT read return and one-IDLE-cycle grant turnaround.
// Backpressure: drivers hold valid until ready; read return is checked every cycle.
module tb_asi_mem_arb;

  localparam int AW   = 40;
  localparam int DW   = 128;
  localparam int BW   = DW / 8;
  localparam int MAW  = 10;
  localparam int LAT  = 3;
  localparam int MAXB = 4;

  logic            usr_clk = 1'b0;
  logic            usr_reset;
  logic            w_valid, w_ready, w_last;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [BW-1:0]   w_strb;
  logic            r_valid, r_ready, r_last;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_valid, rd_last;
  logic            mem_en, mem_we;
  logic [MAW-1:0]  mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_be;
  logic [DW-1:0]   mem_rdata;

  asi_mem_arb #(
    .AXI_AW(AW), .AXI_DW(DW), .MEM_AW(MAW), .RD_LAT(LAT), .MAX_BEATS(MAXB)
  ) dut (
    .usr_clk(usr_clk), .usr_reset(usr_reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_last(r_last),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 usr_clk = ~usr_clk;

  int cyc = 0;
  always @(posedge usr_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SRAM model driven only by the DUT's memory port.
  logic [DW-1:0] sram  [0:(1<<MAW)-1];
  logic [DW-1:0] rpipe [0:LAT-1];
  always @(posedge usr_clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    rpipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  // Shadow memory built from the bench's own stimulus.
  logic [DW-1:0] exp_mem [0:(1<<MAW)-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } rexp_t;
  rexp_t rq[$];
  rexp_t mon_e;

  byte grant_log[$];
  int  wr_acc_cnt = 0, rd_acc_cnt = 0, rd_ret_cnt = 0;
  int  last_w_cyc = 0, w_rise_cyc = 0, r_rise_cyc = 0, wr_at_rgrant = 0;
  int  r_during_w = 0;
  logic wr_busy = 1'b0;
  logic w_prev = 1'b0, r_prev = 1'b0;
  int  widx;

  // Monitor: checks every accepted beat, idle port, and read returns against the scoreboard.
  always @(negedge usr_clk) begin
    if (usr_reset) begin
      w_prev = 1'b0;
      r_prev = 1'b0;
    end else begin
      check("rdy_excl", {127'd0, w_ready & r_ready}, '0);
      if (w_valid && w_ready) begin
        widx = int'(w_addr[MAW+3:4]);
        check("wr_en_we", {126'd0, mem_en, mem_we}, 128'd3);
        check("wr_addr", {118'd0, mem_addr}, 128'(widx));
        check("wr_data", mem_wdata, w_data);
        check("wr_be", {112'd0, mem_be}, {112'd0, w_strb});
        for (int b = 0; b < BW; b++)
          if (w_strb[b]) exp_mem[widx][b*8 +: 8] = w_data[b*8 +: 8];
        wr_acc_cnt++;
        if (w_last) last_w_cyc = cyc;
      end else if (r_valid && r_ready) begin
        widx = int'(r_addr[MAW+3:4]);
        check("rd_en_we", {126'd0, mem_en, mem_we}, 128'd2);
        check("rd_addr", {118'd0, mem_addr}, 128'(widx));
        mon_e.data = exp_mem[widx];
        mon_e.last = r_last;
        mon_e.cyc  = cyc + LAT;
        rq.push_back(mon_e);
        rd_acc_cnt++;
      end else begin
        check("idle_port", {126'd0, mem_en, mem_we}, '0);
      end
      if (wr_busy && r_ready) r_during_w++;
      if (w_ready && !w_prev) begin grant_log.push_back("W"); w_rise_cyc = cyc; end
      if (r_ready && !r_prev) begin
        grant_log.push_back("R"); r_rise_cyc = cyc; wr_at_rgrant = wr_acc_cnt;
      end
      w_prev = w_ready;
      r_prev = r_ready;
      if (rd_valid) begin
        if (rq.size() == 0) begin
          check("rd_spurious", {127'd0, rd_valid}, '0);
        end else begin
          mon_e = rq.pop_front();
          check("rd_data", rd_data, mon_e.data);
          check("rd_last", {127'd0, rd_last}, {127'd0, mon_e.last});
          check("rd_cyc", 128'(cyc), 128'(mon_e.cyc));
          rd_ret_cnt++;
        end
      end
    end
  end

  task automatic wait_w();
    int t = 0;
    @(negedge usr_clk);
    while (!w_ready && t < 200) begin t++; @(negedge usr_clk); end
    if (!w_ready) check("w_timeout", '0, 128'd1);
    @(posedge usr_clk); #1;
  endtask

  task automatic wait_r();
    int t = 0;
    @(negedge usr_clk);
    while (!r_ready && t < 200) begin t++; @(negedge usr_clk); end
    if (!r_ready) check("r_timeout", '0, 128'd1);
    @(posedge usr_clk); #1;
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int n, input logic [BW-1:0] strb,
                          input int gap_after, input int gap_len);
    for (int i = 0; i < n; i++) begin
      w_addr  = addr + AW'(i * BW);
      w_data  = {$urandom, $urandom, $urandom, $urandom};
      w_strb  = strb;
      w_last  = (i == n - 1);
      w_valid = 1'b1;
      wait_w();
      if (i == gap_after) begin
        w_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge usr_clk);
          check("gap_hold", {127'd0, w_ready}, 128'd1);
          @(posedge usr_clk); #1;
        end
      end
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int n);
    for (int i = 0; i < n; i++) begin
      r_addr  = addr + AW'(i * BW);
      r_last  = (i == n - 1);
      r_valid = 1'b1;
      wait_r();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge usr_clk);
    #1;
  endtask

  task automatic do_reset();
    usr_reset = 1'b1;
    idle_cycles(2);
    usr_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int rel_cyc, base, rv_seen;

  initial begin
    usr_reset = 1'b1;
    w_valid = 1'b0; w_last = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    r_valid = 1'b0; r_last = 1'b0; r_addr = '0;
    idle_cycles(3);

    // Reset values.
    @(negedge usr_clk);
    check("rst_ready", {126'd0, w_ready, r_ready}, '0);
    check("rst_mem", {126'd0, mem_en, mem_we}, '0);
    check("rst_rd", {126'd0, rd_valid, rd_last}, '0);
    check("rst_data", rd_data | mem_wdata | DW'(mem_addr) | DW'(mem_be), '0);
    @(posedge usr_clk); #1;

    // Write and read contend out of reset: write first, read after one IDLE cycle.
    usr_reset = 1'b0;
    rel_cyc = cyc;
    fork
      wr_burst(40'h40, 4, '1, -1, 0);
      rd_burst(40'h40, 4);
    join
    idle_cycles(LAT + 3);
    check("first_grant_cyc", 128'(w_rise_cyc), 128'(rel_cyc + 1));
    check("grant_order0", {120'd0, grant_log[0]}, {120'd0, 8'("W")});
    check("r_after_wlast", 128'(r_rise_cyc), 128'(last_w_cyc + 2));
    check("rd_ret_cnt", 128'(rd_ret_cnt), 128'd4);
    for (int k = 4; k < 8; k++) check("sram_word", sram[k], exp_mem[k]);

    // Continuous 2-beat bursts from both sides alternate W,R,W,R...
    do_reset();
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) wr_burst(40'h100 + AW'(k * 32), 2, '1, -1, 0);
      for (int k = 0; k < 4; k++) rd_burst(40'h40 + AW'((k % 2) * 32), 2);
    join
    idle_cycles(LAT + 3);
    check("alt_len", 128'(grant_log.size()), 128'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("alt_order", {120'd0, grant_log[k]}, {120'd0, (k % 2 == 0) ? 8'("W") : 8'("R")});

    // Partial-strobe write with a 2-cycle valid gap holds the grant; read waits.
    do_reset();
    wr_burst(40'h200, 3, '1, -1, 0);
    idle_cycles(2);
    base = wr_acc_cnt;
    r_during_w = 0;
    fork
      begin wr_busy = 1'b1; wr_burst(40'h200, 3, 16'h00FF, 0, 2); wr_busy = 1'b0; end
      begin idle_cycles(2); rd_burst(40'h200, 3); end
    join
    idle_cycles(LAT + 3);
    check("strb_writes", 128'(wr_acc_cnt - base), 128'd3);
    check("r_ready_held0", 128'(r_during_w), '0);
    for (int k = 32; k < 35; k++) check("strb_word", sram[k], exp_mem[k]);

    // Reset during beat 2 of a read: in-flight returns are dropped.
    base = rd_ret_cnt;
    r_addr = 40'h40; r_last = 1'b0; r_valid = 1'b1;
    wait_r();
    r_addr = 40'h50;
    @(negedge usr_clk);
    #2 usr_reset = 1'b1;
    rq.delete();
    r_valid = 1'b0;
    rv_seen = 0;
    @(negedge usr_clk);
    check("rst_mid_ready", {126'd0, w_ready, r_ready}, '0);
    check("rst_mid_mem", {126'd0, mem_en, mem_we}, '0);
    check("rst_mid_rd", {126'd0, rd_valid, rd_last}, '0);
    check("rst_mid_data", rd_data | mem_wdata | DW'(mem_addr) | DW'(mem_be), '0);
    @(posedge usr_clk); #1;
    usr_reset = 1'b0;
    repeat (LAT + 3) begin
      @(negedge usr_clk);
      if (rd_valid) rv_seen++;
    end
    check("rst_no_rdvalid", 128'(rv_seen), '0);
    check("rst_no_return", 128'(rd_ret_cnt - base), '0);
    idle_cycles(1);

`ifdef ASI_ARB_BEATCAP_EN
    // Beat cap: a long write yields to a pending read after MAX_BEATS beats.
    do_reset();
    grant_log.delete();
    base = wr_acc_cnt;
    fork
      wr_burst(40'h400, 32, '1, -1, 0);
      begin wait_w(); rd_burst(40'h40, 1); end
    join
    idle_cycles(LAT + 3);
    check("cap_beats", 128'(wr_at_rgrant - base), 128'(MAXB));
    check("cap_total", 128'(wr_acc_cnt - base), 128'd32);
    check("cap_order_len", 128'(grant_log.size()), 128'd3);
    if (grant_log.size() >= 3) begin
      check("cap_order1", {120'd0, grant_log[1]}, {120'd0, 8'("R")});
      check("cap_order2", {120'd0, grant_log[2]}, {120'd0, 8'("W")});
    end
`endif

    check("sb_empty", 128'(rq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/asi_mem_arb.md
ASI_MEM_ARB -- requirements
Module: asi_mem_arb

Interface
REQ-001 SHALL have parameter AXI_AW, default 40: byte-address width.
REQ-002 SHALL have parameter AXI_DW, default 128: data width; strobe width is AXI_DW/8.
REQ-003 SHALL have parameter MEM_AW, default 10: word-address width of the single-port SRAM.
REQ-004 SHALL have parameter RD_LAT, default 1: SRAM read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter MAX_BEATS, default 16: beat cap per grant when the beat cap is compiled in (REQ-026).
REQ-006 SHALL have these ports, clock and reset first (one clock; reset is asynchronous and active-high):
- usr_clk  in  1  user-side clock
- usr_reset  in  1  asynchronous active-high reset
- w_valid / w_ready  in / out  1  write beat handshake
- w_addr  in  AXI_AW  write byte address
- w_data  in  AXI_DW  write data
- w_strb  in  AXI_DW/8  write byte enables
- w_last  in  1  last beat of a write burst
- r_valid / r_ready  in / out  1  read beat handshake
- r_addr  in  AXI_AW  read byte address
- r_last  in  1  last beat of a read burst
- rd_data  out  AXI_DW  returned read data
- rd_valid  out  1  rd_data qualifier
- rd_last  out  1  returned beat was r_last
- mem_en / mem_we  out  1  SRAM enable / write enable
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata / mem_be  out  AXI_DW / AXI_DW/8  SRAM write data / byte enables
- mem_rdata  in  AXI_DW  SRAM read data, valid RD_LAT cycles after a read enable

Function
REQ-007 SHALL arbitrate the write and read requesters onto the one SRAM port; at most one SRAM access per cycle.
REQ-008 SHALL implement the FSM states IDLE, WBURST and RBURST.
REQ-009 IDLE transitions:
- only w_valid -> WBURST
- only r_valid -> RBURST
- both -> the side named by the round-robin pointer; pointer reset value = write.
REQ-010 Each grant decision in IDLE SHALL take effect in the next cycle; w_ready and r_ready SHALL be 0 in IDLE.
REQ-011 In WBURST, w_ready=1 and r_ready=0; on each accepted write beat, the block SHALL drive mem_en=1, mem_we=1, mem_wdata=w_data and mem_be=w_strb combinationally in the same cycle.
REQ-012 In RBURST, r_ready=1 and w_ready=0; on each accepted read beat, the block SHALL drive mem_en=1 and mem_we=0.
REQ-013 mem_addr SHALL equal addr[MEM_AW+log2(AXI_DW/8)-1 : log2(AXI_DW/8)]; upper address bits are ignored, so addresses wrap modulo the SRAM size.
REQ-014 Burst lock: the grant SHALL be held until a beat with last=1 is accepted, and the FSM SHALL then return to IDLE.
- On that transition, the pointer SHALL toggle to the other side.
REQ-015 A granted side deasserting valid mid-burst SHALL keep the grant: no SRAM access occurs and the FSM stays in its state.
REQ-016 Read return: rd_valid and rd_last SHALL assert exactly RD_LAT cycles after the accepted read beat, via a RD_LAT-deep shift pipe; rd_data SHALL equal mem_rdata in that cycle.
REQ-017 Read return SHALL have no backpressure; the consumer always accepts.
REQ-018 When no access occurs, mem_en=0 and mem_we=0; mem_addr, mem_wdata and mem_be are don't-care but SHALL NOT be X.
REQ-019 Back-to-back bursts: best-case gap is one IDLE cycle between bursts.
- Read-return pipe entries SHALL continue to drain while the write side is granted.

Reset
REQ-020 On usr_reset asserted, asynchronously: FSM=IDLE, pointer=write, beat counter=0, read pipe cleared.
REQ-021 During reset: w_ready=0, r_ready=0, mem_en=0, mem_we=0, rd_valid=0, rd_last=0, and all data outputs=0.
REQ-022 Reset mid-burst SHALL abandon the burst; in-flight read returns SHALL be discarded and never flagged valid.
REQ-023 Deassertion SHALL be synchronous to usr_clk; the first grant is possible in the second cycle after release.

Configuration
REQ-024 Macro ASI_ARB_BEATCAP_EN SHALL compile in the starvation beat cap.
REQ-025 Without the macro, burst lock is absolute per REQ-014.
REQ-026 With the macro:
- An 8-bit beat counter counts accepted beats in the current grant.
- When the count reaches MAX_BEATS and the other side's valid=1, the grant SHALL be released mid-burst: next state IDLE, pointer toggled, counter cleared.
- The preempted burst resumes on a later grant, with address continuity supplied by the requester.

Structure
REQ-027 Package asi_pkg SHALL hold the FSM state enum (arb_state_e: IDLE, WBURST, RBURST) and the side enum (arb_side_e: SIDE_W, SIDE_R).
REQ-028 The read-return delay SHALL be one sub-module, asi_rd_pipe: a RD_LAT-deep valid/last shift register with async clear.

Verification
REQ-029 Single 4-beat write at 0x40, then a 4-beat read at 0x40 -> SRAM words 4..7 are written, and rd_data returns the same data RD_LAT cycles after each r_ready beat, with rd_last on beat 4.
REQ-030 w_valid and r_valid rise in the same cycle out of reset -> the write is granted first; the read is granted after write w_last plus one IDLE cycle.
REQ-031 Continuous write and read requests, each 2 beats -> grants alternate W,R,W,R; no side waits more than one burst.
REQ-032 Write of 3 beats with w_strb=16'h00FF and a w_valid gap of 2 cycles mid-burst -> grant is held, 3 SRAM writes occur, and r_ready stays 0 throughout.
REQ-033 usr_reset pulsed during beat 2 of a read with RD_LAT=3 -> rd_valid never asserts for beats 1-2; all outputs are 0 in the cycle after assertion.
REQ-034 With ASI_ARB_BEATCAP_EN, MAX_BEATS=4: a 32-beat write with r_valid pending -> the write is released after 4 beats, and a 1-beat read is served before the write resumes.
